// File: rtl/mem_data_controller.sv
`default_nettype none
// ============================================================================
// Module  : mem_data_controller
// MEM-stage data memory handshake with big-endian load formatting, alignment
// fault detection and LL/SC link tracking.
// Revision: 1.0
// ============================================================================
module mem_data_controller #(
   parameter int ADDR_WIDTH = 30,
   parameter bit LLSC_EN    = 1'b1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [31:0]           Address,
   input  logic [31:0]           WriteData,
   input  logic                  MemRead,
   input  logic                  MemWrite,
   input  logic                  Byte,
   input  logic                  Half,
   input  logic                  SignExtend,
   input  logic                  LLSC,
   input  logic                  Eret,
   output logic [31:0]           ReadData,
   output logic                  MEM_Stall,
   output logic                  EXC_AdEL,
   output logic                  EXC_AdES,
   input  logic [31:0]           DataMem_In,
   input  logic                  DataMem_Ready,
   output logic                  DataMem_Read,
   output logic [3:0]            DataMem_Write,
   output logic [ADDR_WIDTH-1:0] DataMem_Address,
   output logic [31:0]           DataMem_Out
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic                  rd_q, rd_d;
   logic [3:0]            we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  llbit_q, llbit_d;
   logic [29:0]           lladdr_q, lladdr_d;

   logic        misaligned;
   logic        is_ll;
   logic        is_sc;
   logic        link_ok;
   logic        req;
   logic [3:0]  be;
   logic [31:0] wr_rep;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_fmt;

   always_comb begin
      misaligned = (Half & Address[0]) | (~Byte & ~Half & (Address[1:0] != 2'b00));
      is_ll      = MemRead & LLSC;
      is_sc      = MemWrite & LLSC;
      link_ok    = !LLSC_EN || (llbit_q && (lladdr_q == Address[31:2]));
      // A failing SC never touches memory, so it must not stall either
      req        = (MemRead | MemWrite) & ~misaligned & ~(is_sc & ~link_ok);
      EXC_AdEL   = MemRead & misaligned;
      EXC_AdES   = MemWrite & misaligned;
      MEM_Stall  = req & (state_q != S_DONE);
   end

   always_comb begin
      be     = 4'b1111;
      wr_rep = WriteData;
      if (Byte) begin
         be     = 4'b1000 >> Address[1:0];
         wr_rep = {4{WriteData[7:0]}};
      end else if (Half) begin
         be     = Address[1] ? 4'b0011 : 4'b1100;
         wr_rep = {2{WriteData[15:0]}};
      end
   end

   // Big-endian lane select: byte offset 0 lives in bits 31:24
   always_comb begin
      ld_byte = rdata_q[7:0];
      case (Address[1:0])
         2'd0:    ld_byte = rdata_q[31:24];
         2'd1:    ld_byte = rdata_q[23:16];
         2'd2:    ld_byte = rdata_q[15:8];
         default: ld_byte = rdata_q[7:0];
      endcase
      ld_half = Address[1] ? rdata_q[15:0] : rdata_q[31:16];
      if (Byte) begin
         ld_fmt = {{24{SignExtend & ld_byte[7]}}, ld_byte};
      end else if (Half) begin
         ld_fmt = {{16{SignExtend & ld_half[15]}}, ld_half};
      end else begin
         ld_fmt = rdata_q;
      end
      ReadData = 32'd0;
      if (state_q == S_DONE) begin
         if (is_sc) begin
            ReadData = 32'd1;
         end else if (MemRead) begin
            ReadData = ld_fmt;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      rd_d     = rd_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      llbit_d  = llbit_q;
      lladdr_d = lladdr_q;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               rd_d    = MemRead;
               we_d    = MemWrite ? be : 4'b0000;
               addr_d  = Address[ADDR_WIDTH+1:2];
               wdata_d = wr_rep;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (DataMem_Ready) begin
               rdata_d = DataMem_In;
               rd_d    = 1'b0;
               we_d    = 4'b0000;
               state_d = S_DONE;
               if (is_ll) begin
                  llbit_d  = 1'b1;
                  lladdr_d = Address[31:2];
               end else if (is_sc) begin
                  llbit_d = 1'b0;
               end else if (MemWrite && (Address[31:2] == lladdr_q)) begin
                  llbit_d = 1'b0;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Exception return wins over a link being set in the same cycle
      if (Eret) begin
         llbit_d = 1'b0;
      end
      if (!LLSC_EN) begin
         llbit_d  = 1'b0;
         lladdr_d = 30'd0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         rd_q     <= 1'b0;
         we_q     <= 4'b0000;
         addr_q   <= '0;
         wdata_q  <= 32'd0;
         rdata_q  <= 32'd0;
         llbit_q  <= 1'b0;
         lladdr_q <= 30'd0;
      end else begin
         state_q  <= state_d;
         rd_q     <= rd_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         llbit_q  <= llbit_d;
         lladdr_q <= lladdr_d;
      end
   end

   assign DataMem_Read    = rd_q;
   assign DataMem_Write   = we_q;
   assign DataMem_Address = addr_q;
   assign DataMem_Out     = wdata_q;

endmodule
`default_nettype wire

// File: doc/mem_data_controller.md
Name: mem_data_controller

Overview:
- MEM-stage data memory controller for the 5-stage MIPS pipeline.
- Turns MEM-stage load/store/LL/SC requests into a registered handshake with data memory, and formats load data big-endian.
- Raises MEM_Stall, which the hazard unit takes as MEM_Stall_Controller and which freezes MEM/WB and every stage behind them.
- Detects alignment faults and keeps the LL/SC link state.

Parameters:
- ADDR_WIDTH, 30: word-address width driven to data memory; byte address bits [ADDR_WIDTH+1:2].
- LLSC_EN, 1: 1 = LL/SC link register present; 0 = SC always succeeds and link is never set.

Ports:
- clock  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low reset.
- Address  in  32  MEM-stage byte address.
- WriteData  in  32  store data, already forwarded.
- MemRead  in  1  load request.
- MemWrite  in  1  store request.
- Byte  in  1  byte access.
- Half  in  1  halfword access; Byte=Half=0 means word.
- SignExtend  in  1  sign-extend sub-word loads.
- LLSC  in  1  with MemRead = LL, with MemWrite = SC.
- Eret  in  1  clears the link bit.
- ReadData  out  32  formatted load data, or SC result.
- MEM_Stall  out  1  stall request to the hazard unit.
- EXC_AdEL  out  1  load address error.
- EXC_AdES  out  1  store address error.
- DataMem_In  in  32  read data from memory.
- DataMem_Ready  in  1  memory completes the outstanding access.
- DataMem_Read  out  1  registered read strobe.
- DataMem_Write  out  4  registered byte enables; bit3 = bits 31:24.
- DataMem_Address  out  ADDR_WIDTH  registered word address.
- DataMem_Out  out  32  registered store data, replicated across lanes.

Behaviour:
- Req = (MemRead|MemWrite) & ~misaligned & ~(SC & ~link_ok).
- Misaligned: Half with Address[0]=1, or word with Address[1:0]!=0.
  - EXC_AdEL = MemRead & misaligned; EXC_AdES = MemWrite & misaligned. Both combinational.
  - No memory access and no stall on a fault.
- link_ok = LLbit & (LLAddr == Address[31:2]).
- FSM states: IDLE, WAIT, DONE. MEM_Stall = Req & (state != DONE), combinational.
  - IDLE: if Req, at the edge register the address/strobes/enables/data and go to WAIT.
  - WAIT: hold the strobes. On DataMem_Ready at the edge: capture DataMem_In into rdata, drop the strobes, go to DONE.
  - DONE: MEM_Stall=0 and ReadData driven from rdata; go to IDLE at the next edge.
  - Minimum access is 3 cycles (2 stall cycles). Each extra wait cycle adds one stall cycle.
- DataMem_Ready while in IDLE or DONE is ignored.
- Store enables: byte at a[1:0]=0..3 -> 1000, 0100, 0010, 0001. Half at a[1]=0/1 -> 1100 / 0011. Word -> 1111.
- DataMem_Out: byte stores replicate the byte ×4; half stores replicate the half ×2.
- Load format is big-endian: a[1:0]=0 selects bits 31:24; half a[1]=0 selects 31:16.
  - Sign-extend if SignExtend, else zero-extend.
- Non-memory instructions: ReadData = 0.
- LL completion sets LLbit and sets LLAddr = Address[31:2].
- SC with link_ok: performs the write; ReadData = 32'd1 in DONE; LLbit cleared at completion.
- SC without link_ok: no access, no stall; ReadData = 32'd0 in the same cycle.
- Completed ordinary store to LLAddr clears LLbit. Eret clears LLbit, and takes priority over a simultaneous LL set.
- With LLSC_EN=0: link_ok is forced 1 and LLbit stays 0.
- Reset asserted (any state, including mid-WAIT) gives:
  - state IDLE;
  - DataMem_Read=0, DataMem_Write=0, DataMem_Address=0, DataMem_Out=0;
  - rdata=0, LLbit=0, LLAddr=0.
  - Combinational outputs follow from IDLE.
- Memory must tolerate an abandoned request after reset.
- Inputs are held stable by the pipeline while MEM_Stall=1.

Test Plan:
- LW at 0x100; memory raises Ready 2 cycles after the strobe -> MEM_Stall high 4 cycles; DataMem_Address=0x40; ReadData equals memory word in DONE; single strobe pulse train.
- LB SignExtend=1, Address=0x103, memory word 0x1122_33F4 -> ReadData=0xFFFF_FFF4. LBU same -> 0x0000_00F4.
- SH Address=0x22, WriteData=0x0000_ABCD -> DataMem_Write=0011, DataMem_Out=0xABCD_ABCD.
- LL 0x200, then SC 0x200 -> write issued, ReadData=1. Second SC 0x200 -> no strobe, MEM_Stall=0, ReadData=0. LL, Eret, SC -> fails.
- LW Address=0x102 -> EXC_AdEL=1, MEM_Stall=0, no strobe. SH Address=0x101 -> EXC_AdES=1.
- Drop reset low during WAIT -> strobes 0 immediately, MEM_Stall=0, LLbit=0. Next LW after release completes normally.
